// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous-read instruction memory.
// Owns the fetch PC, tracks the one-cycle read latency and buffers one word across decode stalls.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_SIZE = 1515,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMP_W  = ((ADDR_W > 32) ? ADDR_W : 32) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic                pend, pend_nxt;
  logic [ADDR_W-1:0]   pend_pc, pend_pc_nxt;
  logic                skid_v, skid_v_nxt;
  logic [DATA_W-1:0]   skid, skid_nxt;
  logic [ADDR_W-1:0]   skid_pc, skid_pc_nxt;
  logic [DATA_W-1:0]   inst_nxt;
  logic [ADDR_W-1:0]   inst_pc_nxt;
  logic                inst_valid_nxt;
  logic                fault_nxt;
  logic                addr_ok_c;
  logic                rpc_ok_c;

  assign addr_ok_c = CMP_W'(mem_addr) < CMP_W'(MEM_SIZE);
  assign rpc_ok_c  = CMP_W'(redirect_pc) < CMP_W'(MEM_SIZE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, issue, capture and skid control; redirect > stall > normal
  always_comb begin
    state_nxt      = state;
    mem_addr_nxt   = mem_addr;
    pend_nxt       = 1'b0;
    pend_pc_nxt    = pend_pc;
    skid_v_nxt     = skid_v;
    skid_nxt       = skid;
    skid_pc_nxt    = skid_pc;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_valid_nxt = inst_valid;
    fault_nxt      = fault;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = FETCH;
          mem_addr_nxt = ADDR_W'(RESET_PC);
        end
      end
      default: begin
        if (redirect) begin
          skid_v_nxt     = 1'b0;
          inst_valid_nxt = 1'b0;
          mem_addr_nxt   = redirect_pc;
          state_nxt      = rpc_ok_c ? FETCH : FAULT;
          fault_nxt      = !rpc_ok_c;
        end else begin
          // pend and skid_v are never both set, so at most one source feeds inst
          if (pend && stall && inst_valid) begin
            skid_nxt    = mem_rd;
            skid_pc_nxt = pend_pc;
            skid_v_nxt  = 1'b1;
          end else if (pend) begin
            inst_nxt       = mem_rd;
            inst_pc_nxt    = pend_pc;
            inst_valid_nxt = 1'b1;
          end else if (!stall && skid_v) begin
            inst_nxt    = skid;
            inst_pc_nxt = skid_pc;
            skid_v_nxt  = 1'b0;
          end else if (!stall) begin
            inst_valid_nxt = 1'b0;
          end
          if (state == FETCH && !stall && !skid_v) begin
            if (addr_ok_c) begin
              pend_nxt     = 1'b1;
              pend_pc_nxt  = mem_addr;
              mem_addr_nxt = mem_addr + ADDR_W'(1);
            end else begin
              state_nxt = FAULT;
              fault_nxt = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= ADDR_W'(RESET_PC);
      pend       <= 1'b0;
      pend_pc    <= '0;
      skid_v     <= 1'b0;
      skid       <= '0;
      skid_pc    <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      mem_addr   <= mem_addr_nxt;
      pend       <= pend_nxt;
      pend_pc    <= pend_pc_nxt;
      skid_v     <= skid_v_nxt;
      skid       <= skid_nxt;
      skid_pc    <= skid_pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= inst_valid_nxt;
      busy       <= (state_nxt == FETCH);
      fault      <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized stall/redirect run
// checked against a stream-level model of the delivered instruction sequence.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned MEM_SIZE = 1515;
  localparam int unsigned RESET_PC = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              busy;
  logic              fault;

  int n_checks = 0;
  int n_fail   = 0;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_rd(mem_rd), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: word n holds n + 0x100
  always @(posedge clk) mem_rd <= 32'h100 + 32'(mem_addr);

  function automatic logic [31:0] word(input int unsigned a);
    return 32'h100 + 32'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_checks++; if (busy !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b fault=%b want 0/0", busy, fault); end
    n_checks++; if (inst !== 32'h0 || inst_pc !== '0) begin n_fail++; $display("FAIL reset_inst: got inst=%h pc=%h want 0/0", inst, inst_pc); end
    n_checks++; if (mem_addr !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL reset_addr: got %h want %h", mem_addr, RESET_PC); end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%b valid=%b want 0/0", busy, inst_valid); end
  endtask

  task automatic test_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL start_edge: got busy=%b valid=%b want 1/0", busy, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL start_latency: got valid=%b want 0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(i) || inst !== word(i)) begin
        n_fail++; $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want 1/%h/%h", i, inst_valid, inst_pc, inst, i, word(i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10 && !(inst_valid === 1'b1 && inst_pc == ADDR_W'(5)); i++) tick();
    n_checks++; if (inst_pc !== ADDR_W'(5)) begin n_fail++; $display("FAIL stall_reach: got pc=%h want 5", inst_pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(5) || inst !== 32'h105) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h want 1/5/105", i, inst_valid, inst_pc, inst);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(6) || inst !== 32'h106) begin n_fail++; $display("FAIL skid_out: got v=%b pc=%h inst=%h want 1/6/106", inst_valid, inst_pc, inst); end
    for (int i = 0; i < 4 && !(inst_valid === 1'b1 && inst_pc != ADDR_W'(6)); i++) tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(7) || inst !== 32'h107) begin n_fail++; $display("FAIL skid_next: got v=%b pc=%h inst=%h want 1/7/107", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = ADDR_W'(16'h40);
    tick();
    redirect = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || busy !== 1'b1 || mem_addr !== ADDR_W'(16'h40)) begin n_fail++; $display("FAIL redir_flush: got v=%b busy=%b addr=%h want 0/1/40", inst_valid, busy, mem_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got v=%b pc=%h want valid 0", inst_valid, inst_pc); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(16'h40) || inst !== 32'h140) begin n_fail++; $display("FAIL redir_target: got v=%b pc=%h inst=%h want 1/40/140", inst_valid, inst_pc, inst); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(16'h41)) begin n_fail++; $display("FAIL redir_next: got v=%b pc=%h want 1/41", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirect_pc = ADDR_W'(16'h10);
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || mem_addr !== ADDR_W'(16'h10)) begin n_fail++; $display("FAIL redir_stall_flush: got v=%b addr=%h want 0/10", inst_valid, mem_addr); end
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(16'h10) || inst !== 32'h110) begin n_fail++; $display("FAIL redir_stall_target: got v=%b pc=%h inst=%h want 1/10/110", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_fault_end();
    redirect = 1'b1; redirect_pc = ADDR_W'(MEM_SIZE - 5);
    tick();
    redirect = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(MEM_SIZE - 5 + i) || fault !== (i == 4) || busy !== (i != 4)) begin
        n_fail++; $display("FAIL end_word_%0d: got v=%b pc=%0d fault=%b busy=%b want 1/%0d/%b/%b", i, inst_valid, inst_pc, fault, busy, MEM_SIZE - 5 + i, i == 4, i != 4);
      end
    end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || fault !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL end_fault: got v=%b fault=%b busy=%b want 0/1/0", inst_valid, fault, busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b0 || fault !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL fault_start_ignored: got v=%b fault=%b busy=%b want 0/1/0", inst_valid, fault, busy); end
    redirect = 1'b1; redirect_pc = '0;
    tick();
    redirect = 1'b0;
    n_checks++; if (fault !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fault_clear: got fault=%b busy=%b want 0/1", fault, busy); end
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== 32'h100) begin n_fail++; $display("FAIL fault_resume: got v=%b pc=%h inst=%h want 1/0/100", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_async_reset();
    tick();
    stall = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL async_flags: got v=%b busy=%b fault=%b want 0/0/0", inst_valid, busy, fault); end
    n_checks++; if (inst !== 32'h0 || inst_pc !== '0 || mem_addr !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL async_data: got inst=%h pc=%h addr=%h want 0/0/%h", inst, inst_pc, mem_addr, RESET_PC); end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = ADDR_W'(16'h20);
    tick();
    redirect = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL idle_redirect: got busy=%b v=%b addr=%h want 0/0/%h", busy, inst_valid, mem_addr, RESET_PC); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== '0 || inst !== 32'h100) begin n_fail++; $display("FAIL restart_first: got v=%b pc=%h inst=%h want 1/0/100", inst_valid, inst_pc, inst); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== ADDR_W'(1)) begin n_fail++; $display("FAIL restart_second: got v=%b pc=%h want 1/1", inst_valid, inst_pc); end
  endtask

  // Stream model: words accepted by the consumer must be consecutive from the last redirect target
  task automatic test_random();
    int                mode;
    int unsigned       exp_next;
    int                since_rd;
    int                bub;
    int unsigned       r;
    logic              pv;
    logic [31:0]       pi;
    logic [ADDR_W-1:0] pp;
    logic              st;
    logic              rd;
    logic [ADDR_W-1:0] rpc;
    mode = 0; exp_next = 0; since_rd = 100; bub = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 800; cyc++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = (since_rd >= 60) || ($urandom_range(0, 99) < 4);
      r  = $urandom_range(0, 9);
      if (r < 8)       rpc = ADDR_W'($urandom_range(0, 1000));
      else if (r == 8) rpc = ADDR_W'($urandom_range(MEM_SIZE - 10, MEM_SIZE - 1));
      else             rpc = ADDR_W'($urandom_range(MEM_SIZE, 65535));
      pv = inst_valid; pi = inst; pp = inst_pc;
      stall = st; redirect = rd; redirect_pc = rpc;
      tick();
      if (rd) begin
        since_rd = 0; bub = 0;
        exp_next = 32'(rpc);
        mode = (32'(rpc) < MEM_SIZE) ? 1 : 2;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush @%0d: got v=%b want 0", cyc, inst_valid); end
      end else begin
        since_rd++;
        if (pv === 1'b1 && !st) begin
          n_checks++;
          if (pp !== ADDR_W'(exp_next) || pi !== word(exp_next)) begin
            n_fail++; $display("FAIL rand_order @%0d: got pc=%h inst=%h want %h/%h", cyc, pp, pi, ADDR_W'(exp_next), word(exp_next));
          end
          exp_next++;
        end
        if (pv === 1'b1 && st) begin
          n_checks++;
          if (inst_valid !== 1'b1 || inst !== pi || inst_pc !== pp) begin
            n_fail++; $display("FAIL rand_hold @%0d: got v=%b pc=%h inst=%h want 1/%h/%h", cyc, inst_valid, inst_pc, inst, pp, pi);
          end
        end
        if (mode == 1 && fault === 1'b1) begin
          n_checks++;
          if (!(exp_next == MEM_SIZE || (inst_valid === 1'b1 && inst_pc == ADDR_W'(MEM_SIZE - 1)))) begin
            n_fail++; $display("FAIL rand_early_fault @%0d: got fault with next pc %0d want %0d", cyc, exp_next, MEM_SIZE);
          end
          mode = 2;
        end
        if (inst_valid === 1'b1) bub = 0;
        else if (mode == 1 && !st) bub++;
        if (bub > 3) begin
          n_checks++; n_fail++; bub = 0;
          $display("FAIL rand_starve @%0d: got no valid word for 4 unstalled cycles want at most 3", cyc);
        end
      end
      if (mode != 0) begin
        n_checks++;
        if (busy !== (mode == 1) || fault !== (mode == 2)) begin
          n_fail++; $display("FAIL rand_mode @%0d: got busy=%b fault=%b want %b/%b", cyc, busy, fault, mode == 1, mode == 2);
        end
      end
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_fault_end();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the synchronous-read instruction memory for the CPU front end.
- Owns the fetch PC and drives the memory word address.
- Tracks the one-cycle read latency and delivers each instruction with its PC and a valid flag.
- Supports decode-side stall (one-entry skid buffer, no lost words), branch/jump redirect with flush, and an out-of-range fault stop.

Parameters:
ADDR_W, 16, width of word address and PC
MEM_SIZE, 1515, number of valid instruction words; addresses >= MEM_SIZE fault
RESET_PC, 0, first fetch address after start

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins fetching at RESET_PC from IDLE
stall  in  1  consumer cannot accept; hold the current output
redirect  in  1  one-cycle pulse; flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch word address
mem_addr  out  ADDR_W  registered word address to instruction memory
mem_rd  in  32  memory read data; valid the cycle after mem_addr was sampled
inst  out  32  registered instruction
inst_pc  out  ADDR_W  word address of inst
inst_valid  out  1  inst/inst_pc are valid
busy  out  1  state is FETCH
fault  out  1  sticky; fetch address out of range

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; mem_addr=RESET_PC.
  - inst=0, inst_pc=0, inst_valid=0, busy=0, fault=0.
  - pend=0, skid_v=0.
- Internal state:
  - pend: the word for the address issued last cycle appears on mem_rd this cycle; pend_pc holds that address.
  - skid_v / skid / skid_pc: one-entry holding buffer.
- States: IDLE, FETCH, FAULT. Transition priority each edge: redirect > stall > normal.
- IDLE:
  - Outputs hold. redirect and stall are ignored.
  - start → FETCH with mem_addr=RESET_PC. No issue occurs on the start edge.
- FETCH, issue: an issue happens on an edge when state is FETCH, redirect=0, stall=0 and skid_v=0.
  - pend<=1, pend_pc<=mem_addr, mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_W).
  - Otherwise pend<=0 and mem_addr holds.
- FETCH, range check: if mem_addr >= MEM_SIZE at an issue opportunity:
  - Go to FAULT; fault<=1; no issue.
  - Words already in flight still drain normally.
- Capture when pend=1:
  - stall=0, or inst_valid=0: inst<=mem_rd, inst_pc<=pend_pc, inst_valid<=1.
  - stall=1 and inst_valid=1: skid<=mem_rd, skid_pc<=pend_pc, skid_v<=1. inst holds.
- Output advance:
  - When stall=0 and skid_v=1: inst<=skid, inst_pc<=skid_pc, skid_v<=0. Issue resumes on the following edge.
  - When stall=0 and nothing captured or skidded: inst_valid<=0.
  - When stall=1: inst, inst_pc and inst_valid hold.
- Latency: an address issued at edge k produces inst_valid at edge k+1. First valid instruction appears 2 edges after the start edge.
- Redirect (FETCH or FAULT):
  - Flush: pend<=0, skid_v<=0, inst_valid<=0.
  - mem_addr<=redirect_pc.
  - If redirect_pc < MEM_SIZE: state FETCH, fault<=0. Otherwise: state FAULT, fault<=1.
  - Redirect simultaneous with stall: redirect wins and the stall is ignored that edge.
- FAULT:
  - No issue; busy=0.
  - Only redirect (or reset) leaves FAULT. start is ignored.
- busy=1 exactly while the state is FETCH.
- Reset mid-operation: in-flight and skid data are discarded; the block returns to IDLE.
- Throughput: one instruction per cycle with no stalls, and no bubbles except after redirect, after start, or when the skid drains.

Test Plan:
1. Reset, then start, with the memory holding word n = n+0x100 → inst_valid rises 2 edges after start; inst_pc goes 0,1,2,3 on consecutive cycles with inst = 0x100,0x101,...; busy=1.
2. stall held 3 cycles while inst_pc=5 → inst stays 0x105 throughout and 0x106 is captured in skid. On release the outputs are 0x106 then 0x107 with no word lost or duplicated.
3. redirect with redirect_pc=0x40 while streaming → inst_valid=0 next cycle; inst_pc=0x40 two edges after redirect; the in-flight old word is never output.
4. redirect and stall asserted the same cycle, redirect_pc=0x10 → flush occurs and stall is ignored; inst_pc=0x10 appears 2 edges later.
5. Streaming up to the last word with MEM_SIZE=1515 → the word at address 1514 is delivered, then fault=1, busy=0, inst_valid=0. A subsequent redirect to 0 clears fault and resumes fetching.
6. rst_n pulled low asynchronously mid-stream with a skid entry held → all outputs go to 0 immediately and the state is IDLE. A redirect issued while IDLE has no effect.
